instr_fetch_mem: RTL
====================

Name: instr_fetch_mem

Overview:
Parametrised, pipelined instruction memory for the ARM core's fetch stage.
- Word-organised storage, loaded at run time through a dedicated program port; contents are not hard-wired at reset.
- Fetch side: valid/ready request from the IF stage, configurable read latency, back-pressure and a flush for taken branches.
- Responses carry the PC, the instruction and a fault code (misaligned / out of range).

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 32, PC width (byte address).
- DEPTH_WORDS, 64, number of instruction words stored; legal byte addresses are 0 .. 4*DEPTH_WORDS-4.
- READ_LAT, 1, cycles from request acceptance to response valid; legal range 1..4.
- FAULT_WORD, 32'hE1A00000, instruction returned on a fault (MOV R0,R0 NOP).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  write one word into memory this cycle.
- prog_addr  in  $clog2(DEPTH_WORDS)  word index for the write.
- prog_data  in  DATA_W  word to write.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request can be accepted.
- req_pc  in  ADDR_W  byte PC to fetch.
- flush  in  1  discard all in-flight fetches.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_pc  out  ADDR_W  PC of the response.
- rsp_instr  out  DATA_W  fetched instruction, or FAULT_WORD.
- rsp_fault  out  2  00 ok, 01 misaligned (req_pc[1:0]!=0), 10 out of range; misaligned wins if both apply.
- fetch_count  out  32  count of delivered responses (rsp_valid & rsp_ready), wraps at 2^32.

Behaviour:
- Reset (async): all stage valid bits = 0, rsp_valid = 0, rsp_pc = 0, rsp_instr = 0, rsp_fault = 0, fetch_count = 0.
- Reset does not alter memory contents.
- Pipeline:
  - READ_LAT stages; each stage holds valid, pc, instr, fault. rsp_* come straight from the last stage's registers.
  - stall = rsp_valid & ~rsp_ready. req_ready = ~stall. When stall = 1 every stage holds.
- Accept: on req_valid & req_ready, stage 1 captures pc, the fault code, and instr = mem[req_pc >> 2] (FAULT_WORD on any fault).
- Latency: a request accepted at edge t is on rsp_* from edge t+READ_LAT, provided there is no stall.
- Throughput: one fetch per cycle while rsp_ready = 1.
- Flush:
  - Clears the valid bit of every stage on the same edge, even when stalled.
  - A request presented in the flush cycle is accepted, because it is the branch target; req_ready is forced to 1 during flush.
  - An accepted response (rsp_valid & rsp_ready) in the flush cycle still counts in fetch_count.
- Program port:
  - Writes are synchronous, independent of stall and flush.
  - Read and write of the same word in the same cycle: the read returns the old word (read-before-write).
  - prog_addr >= DEPTH_WORDS is ignored.
- Out of range: req_pc >> 2 >= DEPTH_WORDS gives fault 10; the memory is not indexed.
- fetch_count increments by 1 on each edge where rsp_valid & rsp_ready; 32'hFFFFFFFF wraps to 0.
- rsp_* stay stable while rsp_valid = 1 and rsp_ready = 0.

Decomposition:
- Shared package arm_pkg holds:
  - fault-code constants FLT_OK = 2'b00, FLT_MISALIGN = 2'b01, FLT_OOR = 2'b10;
  - the NOP encoding;
  - the fetch-response struct {valid, pc, instr, fault}.
- One sub-module, imem_array: parametrised DEPTH_WORDS x DATA_W storage with one write port and one combinational read port.
- instr_fetch_mem contains the pipeline, handshake, flush and counter logic.

Test Plan:
- Load words 0..7 = 32'h1000_0000+i, READ_LAT=1, stream PC 0,4,...,28 with rsp_ready=1 -> rsp_instr 0x10000000..0x10000007 on consecutive cycles, each 1 cycle after accept; fetch_count=8.
- READ_LAT=3, single fetch of PC 8 -> rsp_valid rises exactly 3 cycles after accept with instr 0x10000002.
- Back-pressure: hold rsp_ready=0 for 4 cycles mid-stream -> req_ready=0, rsp_* frozen, no responses lost or duplicated, fetch_count unchanged during the stall.
- Flush with READ_LAT=2:
  - flush while PCs 0x10 and 0x14 are in flight, and request PC 0x4 in the same cycle -> 0x10/0x14 never appear; next response is PC 4.
  - repeat with flush during a stall -> pipeline still cleared.
- Faults:
  - PC 0x6 -> fault 01, instr 0xE1A00000.
  - PC 4*DEPTH_WORDS -> fault 10.
  - PC 4*DEPTH_WORDS+2 -> fault 01.
- Same-cycle prog write to word 3 (0xDEADBEEF) and fetch of PC 12 -> old word returned; refetch -> 0xDEADBEEF; assert rst mid-stream -> rsp_valid=0 and fetch_count=0 immediately, memory retains 0xDEADBEEF.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM fetch path: fault codes, the NOP used as the
// fault filler, and the fetch-response record.
package arm_pkg;
  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_OOR      = 2'b10;

  // MOV R0,R0
  localparam logic [31:0] ARM_NOP = 32'hE1A00000;

  localparam int ARM_DATA_W = 32;
  localparam int ARM_ADDR_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [ARM_ADDR_W-1:0] pc;
    logic [ARM_DATA_W-1:0] instr;
    logic [1:0]            fault;
  } fetch_rsp_t;

  // Misalignment takes priority over out-of-range.
  function automatic logic [1:0] fault_code(input logic misalign, input logic oor);
    if (misalign) return FLT_MISALIGN;
    if (oor)      return FLT_OOR;
    return FLT_OK;
  endfunction
endpackage

// File: rtl/instr_fetch_mem_if.sv
// Fetch-side bus between the IF stage (master) and the instruction memory
// (slave): request handshake, flush, and response handshake with pc/instr/fault.
interface instr_fetch_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_pc;
  logic [DATA_W-1:0] rsp_instr;
  logic [1:0]        rsp_fault;

  modport master (
    output req_valid, req_pc, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_pc, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/imem_array.sv
// DEPTH_WORDS x DATA_W instruction storage, one synchronous write port and one
// combinational read port. A read in the same cycle as a write to the same
// word sees the old contents. Not reset: contents survive rst.
//   clk          : clock
//   we/waddr/wdata : write port, waddr >= DEPTH_WORDS is dropped
//   raddr/rdata  : asynchronous read port
module imem_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 64,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic              wr_ok;

  // Only a non-power-of-two depth can see an index past the end.
  if (DEPTH_WORDS == (1 << AW)) begin : g_full
    assign wr_ok = 1'b1;
  end else begin : g_part
    assign wr_ok = ({1'b0, waddr} < (AW+1)'(DEPTH_WORDS));
  end

  always_ff @(posedge clk)
    if (we && wr_ok) mem_q[waddr] <= wdata;

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/instr_fetch_mem.sv
// Pipelined instruction memory for the fetch stage.
//   clk, rst          : clock, async active-high reset
//   prog_we/addr/data : run-time program load port (one word per cycle)
//   fif               : fetch bus (request, flush, response)
//   fetch_count       : number of delivered responses, wraps at 2^32
// READ_LAT (1..4) register stages sit between acceptance and rsp_*; the last
// stage drives the response directly. A held response freezes every stage.
module instr_fetch_mem
  import arm_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 64,
  parameter int                READ_LAT    = 1,
  parameter logic [DATA_W-1:0] FAULT_WORD  = DATA_W'(ARM_NOP),
  localparam int               AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  instr_fetch_mem_if.slave  fif,
  output logic [31:0]       fetch_count
);
  logic [READ_LAT:1]             vld_pipe_q, vld_pipe_d;
  logic [READ_LAT:1][ADDR_W-1:0] pc_pipe_q, pc_pipe_d;
  logic [READ_LAT:1][DATA_W-1:0] instr_pipe_q, instr_pipe_d;
  logic [READ_LAT:1][1:0]        flt_pipe_q, flt_pipe_d;
  logic [31:0]                   fetch_count_q, fetch_count_d;

  logic              stall, adv, accept, xfer;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        flt;
  logic [DATA_W-1:0] rdata;

  imem_array #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (word_idx[AW-1:0]),
    .rdata (rdata)
  );

  assign stall    = fif.rsp_valid & ~fif.rsp_ready;
  // Flush carries the branch target, so it always gets in.
  assign adv      = ~stall | fif.flush;
  assign accept   = fif.req_valid & adv;
  assign xfer     = fif.rsp_valid & fif.rsp_ready;
  assign word_idx = fif.req_pc >> 2;
  assign flt      = fault_code(|fif.req_pc[1:0], word_idx >= ADDR_W'(DEPTH_WORDS));

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    pc_pipe_d     = pc_pipe_q;
    instr_pipe_d  = instr_pipe_q;
    flt_pipe_d    = flt_pipe_q;
    fetch_count_d = fetch_count_q + 32'(xfer);
    if (adv) begin
      vld_pipe_d[1]   = accept;
      pc_pipe_d[1]    = fif.req_pc;
      instr_pipe_d[1] = (flt != FLT_OK) ? FAULT_WORD : rdata;
      flt_pipe_d[1]   = flt;
      // Older fetches are dropped on flush; only the new target survives.
      for (int k = 2; k <= READ_LAT; k++) begin
        vld_pipe_d[k]   = vld_pipe_q[k-1] & ~fif.flush;
        pc_pipe_d[k]    = pc_pipe_q[k-1];
        instr_pipe_d[k] = instr_pipe_q[k-1];
        flt_pipe_d[k]   = flt_pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe_q    <= '0;
      pc_pipe_q     <= '0;
      instr_pipe_q  <= '0;
      flt_pipe_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      pc_pipe_q     <= pc_pipe_d;
      instr_pipe_q  <= instr_pipe_d;
      flt_pipe_q    <= flt_pipe_d;
      fetch_count_q <= fetch_count_d;
    end

  assign fif.req_ready = adv;
  assign fif.rsp_valid = vld_pipe_q[READ_LAT];
  assign fif.rsp_pc    = pc_pipe_q[READ_LAT];
  assign fif.rsp_instr = instr_pipe_q[READ_LAT];
  assign fif.rsp_fault = flt_pipe_q[READ_LAT];
  assign fetch_count   = fetch_count_q;
endmodule
